i2s_slave_rx: RTL and testbench
===============================

# i2s_slave_rx

I2S receiver for the audio clock domain, and the counterpart of the I2S master transmitter. It oversamples externally driven SCLK, LRCLK and SDIN pins with `clk_audio` (12.288 MHz, 4× a 3.072 MHz SCLK) and deserialises standard I2S frames (MSB first, one-bit delay after each LRCLK edge). Each complete stereo frame is presented as a left/right sample pair with a one-cycle valid strobe. It feeds the synth's audio input path and serves as the loopback checker for the transmitter.

## Interface
- `DATA_W`, 24: sample width in bits; legal range 1..`SLOT_W`-1.
- `SLOT_W`, 32: SCLK periods per channel slot; a frame is 2×`SLOT_W` periods.
- `clk_audio`  in  1  12.288 MHz audio clock; all logic is on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `i2s_sclk`  in  1  bit clock pin; asynchronous to `clk_audio` phase.
- `i2s_lrclk`  in  1  word select pin; 0 = left, 1 = right.
- `i2s_din`  in  1  serial data pin.
- `data_l`  out  `DATA_W`  last complete left sample.
- `data_r`  out  `DATA_W`  last complete right sample.
- `valid`  out  1  one-cycle pulse when `data_l`/`data_r` update.
- `frame_err`  out  1  one-cycle pulse on a malformed channel slot.

## Operation
- **Input synchronisation:** all three pins pass through 2-flop synchronisers. `sclk_rise` is asserted for one cycle when the synced SCLK is 1 and its previous value was 0.
- **Sampling:** all sampling happens only on `sclk_rise` cycles, which read synced LRCLK and DIN. `lr_prev` holds the LRCLK value from the previous `sclk_rise`.
- **Slot counter:** `slot_cnt` is 6 bits. On an LRCLK change it is cleared to 0; otherwise it increments, saturating at 63.
  - Slot 0 is the delay bit and is ignored.
  - Slots 1..`DATA_W` shift DIN into `shreg` MSB first.
  - Slots after `DATA_W` are ignored.
- **FSM states:** HUNT, LEFT, RIGHT.
  - HUNT: when LRCLK changes 1→0 at a `sclk_rise`, go to LEFT. All other LRCLK activity is ignored, with no error.
  - LEFT: at slot `DATA_W`, copy `shreg` into `left_hold`. When LRCLK changes 0→1: if `slot_cnt`==`SLOT_W`-1, go to RIGHT; otherwise pulse `frame_err` and go to HUNT.
  - RIGHT: at slot `DATA_W`, set `data_l`←`left_hold`, `data_r`←`shreg` including the final bit, and pulse `valid`. When LRCLK changes 1→0: if `slot_cnt`==`SLOT_W`-1, go to LEFT; otherwise pulse `frame_err` and go to HUNT. In both cases this edge is the start of a new left slot, so on the error path HUNT sees it already consumed and waits for the next 1→0.
- **Output hold:** `data_l`/`data_r` hold their values between `valid` pulses. A frame rejected by `frame_err` never produces `valid`.
- **Saturated counter:** a saturated `slot_cnt` (stalled LRCLK) counts as a length mismatch at the next LRCLK edge.

## Timing
- **Reset:** all outputs, synchroniser flops, `shreg`, `left_hold` and `slot_cnt` are 0 after reset; `lr_prev` is 0 and the FSM is in HUNT. Reset asserted mid-frame discards the partial frame; after release the first `valid` requires a full LEFT+RIGHT pass.
- **Edge detection:** a pin SCLK rise is seen as `sclk_rise` 3 `clk_audio` cycles later.
- **Output latency:** `valid`, `data_l` and `data_r` change in the cycle after the `sclk_rise` of right slot `DATA_W`, about 4 cycles after that pin edge.
- **`frame_err` latency:** asserted in the cycle after the offending `sclk_rise`.
- **Mutual exclusion:** `valid` and `frame_err` are never high in the same cycle.
- **Pin requirements:** SCLK high and low phases must each be ≥2 `clk_audio` cycles. DIN and LRCLK must change only near the SCLK falling edge.
- **Nominal rate:** with SCLK = `clk_audio`/4 and `SLOT_W`=32, `valid` pulses every 256 cycles.
- **First output:** first `valid` arrives within 2 frames (≤512 cycles) of the first LRCLK activity.

## Structure
- **Shared package `i2s_pkg`:** holds `I2S_DATA_W`=24, `I2S_SLOT_W`=32 and `typedef enum logic [1:0] {HUNT, LEFT, RIGHT} i2s_rx_state_t`. The transmitter should migrate to these constants.
- **Sub-module `i2s_pin_sync`:** 2-flop synchroniser for SCLK, LRCLK and DIN plus the SCLK rise detector; outputs synced LRCLK/DIN and `sclk_rise`. Instantiated once.
- **Top level:** FSM, slot counter, shift register and hold/output registers live in `i2s_slave_rx`.

## Test plan
- **Loopback, constant data:** drive from the I2S master with `data_l`=0x123456, `data_r`=0xABCDEF → `valid` every 256 cycles with exactly those values; first `valid` within 512 cycles; `frame_err` never asserted.
- **Bit-order patterns:** alternate frames of L=0x800000/R=0x000001 and L=0x000001/R=0x800000 → received values match per frame, with no MSB/LSB swap or off-by-one shift.
- **Reset values:** hold `reset_n`=0 for 10 cycles with pins toggling → all outputs 0. Release mid-right-slot → no `valid` until the next complete LEFT+RIGHT, then correct data.
- **Short slot:** bench-driven frame with a 31-period left slot → one `frame_err` pulse, no `valid` for that frame, and FSM recovery with correct data within 2 frames.
- **Stalled LRCLK:** hold LRCLK at 0 for 100 SCLK periods, then resume normal frames → single `frame_err`, then normal `valid` stream.
- **Mid-frame data change:** change master `data_l` mid-frame → each received pair equals a latched pair; no mixed-bit values.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S constants, receiver state encoding and slot-counter helper.
// The transmitter is expected to take its frame geometry from here as well.
package i2s_pkg;

  localparam int I2S_DATA_W = 24;
  localparam int I2S_SLOT_W = 32;
  localparam int I2S_CNT_W  = 6;

  localparam logic [I2S_CNT_W-1:0] I2S_CNT_MAX = '1;

  typedef enum logic [1:0] {
    HUNT,
    LEFT,
    RIGHT
  } i2s_rx_state_t;

  // Restart on a word-select edge, otherwise count up and stick at the top so a
  // stalled LRCLK can never wrap back into a legal slot length.
  function automatic logic [I2S_CNT_W-1:0] slot_next(
    input logic [I2S_CNT_W-1:0] cnt,
    input logic                 restart
  );
    if (restart) begin
      return '0;
    end else if (cnt == I2S_CNT_MAX) begin
      return cnt;
    end else begin
      return cnt + I2S_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/i2s_pin_sync.sv
// Two-flop synchronisers for the I2S pins plus a registered SCLK rise strobe.
// LRCLK/DIN leave here aligned with the strobe that should sample them.
module i2s_pin_sync
  import i2s_pkg::*;
(
  input  logic clk_audio,
  input  logic reset_n,
  input  logic i2s_sclk,
  input  logic i2s_lrclk,
  input  logic i2s_din,
  output logic lrclk_sync,
  output logic din_sync,
  output logic sclk_rise
);

  logic [2:0] meta_q, meta_d;
  logic [2:0] sync_q, sync_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic       rise_q, rise_d;
  logic       lrclk_q, lrclk_d;
  logic       din_q, din_d;

  always_comb begin
    meta_d      = {i2s_sclk, i2s_lrclk, i2s_din};
    sync_d      = meta_q;
    sclk_prev_d = sync_q[2];
    rise_d      = sync_q[2] & ~sclk_prev_q;
    lrclk_d     = sync_q[1];
    din_d       = sync_q[0];
  end

  always_ff @(posedge clk_audio) begin
    if (!reset_n) begin
      meta_q      <= '0;
      sync_q      <= '0;
      sclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      din_q       <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      sclk_prev_q <= sclk_prev_d;
      rise_q      <= rise_d;
      lrclk_q     <= lrclk_d;
      din_q       <= din_d;
    end
  end

  assign lrclk_sync = lrclk_q;
  assign din_sync   = din_q;
  assign sclk_rise  = rise_q;

endmodule

// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: oversampled pins, slot counting, deserialisation and
// per-frame left/right hand-off with slot-length checking.
module i2s_slave_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W = I2S_DATA_W,
  parameter int SLOT_W = I2S_SLOT_W
) (
  input  logic              clk_audio,
  input  logic              reset_n,
  input  logic              i2s_sclk,
  input  logic              i2s_lrclk,
  input  logic              i2s_din,
  output logic [DATA_W-1:0] data_l,
  output logic [DATA_W-1:0] data_r,
  output logic              valid,
  output logic              frame_err
);

  logic lrclk_sync;
  logic din_sync;
  logic sclk_rise;

  i2s_pin_sync u_pin_sync (
    .clk_audio (clk_audio),
    .reset_n   (reset_n),
    .i2s_sclk  (i2s_sclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_din   (i2s_din),
    .lrclk_sync(lrclk_sync),
    .din_sync  (din_sync),
    .sclk_rise (sclk_rise)
  );

  i2s_rx_state_t          state_q, state_d;
  logic                   lr_prev_q, lr_prev_d;
  logic [I2S_CNT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic [DATA_W-1:0]      left_hold_q, left_hold_d;
  logic [DATA_W-1:0]      data_l_q, data_l_d;
  logic [DATA_W-1:0]      data_r_q, data_r_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;

  logic lr_edge;
  logic in_data;
  logic last_bit;
  logic slot_full;

  always_comb begin
    state_d     = state_q;
    lr_prev_d   = lr_prev_q;
    slot_cnt_d  = slot_cnt_q;
    shreg_d     = shreg_q;
    left_hold_d = left_hold_q;
    data_l_d    = data_l_q;
    data_r_d    = data_r_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    lr_edge     = 1'b0;
    in_data     = 1'b0;
    last_bit    = 1'b0;
    slot_full   = 1'b0;

    if (sclk_rise) begin
      lr_edge    = (lrclk_sync != lr_prev_q);
      lr_prev_d  = lrclk_sync;
      slot_cnt_d = slot_next(slot_cnt_q, lr_edge);
      // Slot 0 after each word-select edge is the I2S delay bit.
      in_data    = !lr_edge && (int'(slot_cnt_d) >= 1) && (int'(slot_cnt_d) <= DATA_W);
      last_bit   = !lr_edge && (int'(slot_cnt_d) == DATA_W);
      slot_full  = (int'(slot_cnt_q) == SLOT_W - 1);

      if (in_data) begin
        shreg_d = (shreg_q << 1) | DATA_W'(din_sync);
      end

      case (state_q)
        HUNT: begin
          if (lr_edge && !lrclk_sync) begin
            state_d = LEFT;
          end
        end
        LEFT: begin
          if (last_bit) begin
            left_hold_d = shreg_d;
          end
          if (lr_edge) begin
            if (slot_full) begin
              state_d = RIGHT;
            end else begin
              frame_err_d = 1'b1;
              state_d     = HUNT;
            end
          end
        end
        RIGHT: begin
          if (last_bit) begin
            data_l_d = left_hold_q;
            data_r_d = shreg_d;
            valid_d  = 1'b1;
          end
          // A bad right slot still ends on a new left slot edge, which HUNT
          // has then already missed; recovery waits for the following frame.
          if (lr_edge) begin
            if (slot_full) begin
              state_d = LEFT;
            end else begin
              frame_err_d = 1'b1;
              state_d     = HUNT;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_audio) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      lr_prev_q   <= 1'b0;
      slot_cnt_q  <= '0;
      shreg_q     <= '0;
      left_hold_q <= '0;
      data_l_q    <= '0;
      data_r_q    <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lr_prev_q   <= lr_prev_d;
      slot_cnt_q  <= slot_cnt_d;
      shreg_q     <= shreg_d;
      left_hold_q <= left_hold_d;
      data_l_q    <= data_l_d;
      data_r_q    <= data_r_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data_l    = data_l_q;
  assign data_r    = data_r_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Directed bench for i2s_slave_rx: a behavioural I2S master drives the pins at
// clk_audio/4 and received pairs/errors are compared against hand-set values.
module tb_i2s_slave_rx;

  localparam int DW = 24;
  localparam int SW = 32;

  logic          clk_audio = 1'b0;
  logic          reset_n   = 1'b0;
  logic          sclk      = 1'b0;
  logic          lrclk     = 1'b0;
  logic          din       = 1'b0;
  logic [DW-1:0] data_l;
  logic [DW-1:0] data_r;
  logic          valid;
  logic          frame_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int bit_cyc  = 0;
  int frame_cyc = 0;

  logic [DW-1:0] q_l[$];
  logic [DW-1:0] q_r[$];
  int            q_cyc[$];
  int            err_cnt  = 0;
  int            err_cyc  = 0;
  int            both_cnt = 0;

  logic [DW-1:0] master_l = '0;
  logic [DW-1:0] master_r = '0;

  i2s_slave_rx #(.DATA_W(DW), .SLOT_W(SW)) dut (
    .clk_audio(clk_audio),
    .reset_n  (reset_n),
    .i2s_sclk (sclk),
    .i2s_lrclk(lrclk),
    .i2s_din  (din),
    .data_l   (data_l),
    .data_r   (data_r),
    .valid    (valid),
    .frame_err(frame_err)
  );

  always #5 clk_audio = ~clk_audio;

  always @(posedge clk_audio) cyc <= cyc + 1;

  always @(negedge clk_audio) begin
    if (valid) begin
      q_l.push_back(data_l);
      q_r.push_back(data_r);
      q_cyc.push_back(cyc);
    end
    if (frame_err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (valid && frame_err) both_cnt = both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One SCLK period: LRCLK/DIN change with the falling edge, 2 cycles low, 2 high.
  task automatic send_bit(input logic lr, input logic d);
    @(negedge clk_audio);
    bit_cyc = cyc;
    sclk  = 1'b0;
    lrclk = lr;
    din   = d;
    @(negedge clk_audio);
    @(negedge clk_audio);
    sclk = 1'b1;
    @(negedge clk_audio);
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input int llen, input int rlen);
    for (int i = 0; i < llen; i++) begin
      send_bit(1'b0, (i >= 1 && i <= DW) ? l[DW-i] : 1'b0);
      if (i == 0) frame_cyc = bit_cyc;
    end
    for (int i = 0; i < rlen; i++) begin
      send_bit(1'b1, (i >= 1 && i <= DW) ? r[DW-i] : 1'b0);
    end
  endtask

  task automatic send_master(input int n);
    logic [DW-1:0] ml;
    logic [DW-1:0] mr;
    for (int k = 0; k < n; k++) begin
      ml = master_l;
      mr = master_r;
      send_frame(ml, mr, SW, SW);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int vb;
    int eb;
    int rel_cyc;
    int f0;
    int sc;
    logic [DW-1:0] pat_l[4];
    logic [DW-1:0] pat_r[4];
    logic [DW-1:0] exp_l[3];

    // Reset held while the pins toggle through a left slot and part of a right slot.
    reset_n = 1'b0;
    repeat (3) @(negedge clk_audio);
    for (int i = 0; i < SW; i++) send_bit(1'b0, i[0]);
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1);
    chk("rst_data_l", 32'(data_l), 32'h0);
    chk("rst_data_r", 32'(data_r), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_no_valid_seen", q_l.size(), 0);

    reset_n = 1'b1;
    rel_cyc = cyc;
    for (int i = 10; i < SW; i++) send_bit(1'b1, 1'b0);
    chk("partial_no_valid", q_l.size(), 0);
    chk("partial_no_err", err_cnt, 0);

    // Constant loopback data.
    vb = q_l.size();
    eb = err_cnt;
    f0 = 0;
    for (int f = 0; f < 4; f++) begin
      send_frame(24'h123456, 24'hABCDEF, SW, SW);
      if (f == 0) f0 = frame_cyc;
    end
    chk("const_count", q_l.size() - vb, 4);
    if (q_l.size() - vb >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("const_l%0d", i), 32'(q_l[vb+i]), 32'h123456);
        chk($sformatf("const_r%0d", i), 32'(q_r[vb+i]), 32'hABCDEF);
      end
      // Right slot bit 24 is SCLK period 56 of the frame; rise seen 3 cycles
      // after the pin edge, outputs one cycle later.
      chk("first_valid_latency", q_cyc[vb] - f0, 230);
      chk("first_valid_window", 32'((q_cyc[vb] - rel_cyc) <= 512), 32'h1);
      for (int i = 1; i < 4; i++)
        chk($sformatf("const_period%0d", i), q_cyc[vb+i] - q_cyc[vb+i-1], 256);
    end
    chk("const_no_err", err_cnt - eb, 0);

    // Bit-order patterns.
    pat_l[0] = 24'h800000; pat_r[0] = 24'h000001;
    pat_l[1] = 24'h000001; pat_r[1] = 24'h800000;
    pat_l[2] = 24'h800000; pat_r[2] = 24'h000001;
    pat_l[3] = 24'h000001; pat_r[3] = 24'h800000;
    vb = q_l.size();
    for (int f = 0; f < 4; f++) send_frame(pat_l[f], pat_r[f], SW, SW);
    chk("order_count", q_l.size() - vb, 4);
    if (q_l.size() - vb >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("order_l%0d", i), 32'(q_l[vb+i]), 32'(pat_l[i]));
        chk($sformatf("order_r%0d", i), 32'(q_r[vb+i]), 32'(pat_r[i]));
      end
    end

    // Short left slot (31 periods).
    vb = q_l.size();
    eb = err_cnt;
    send_frame(24'h111111, 24'h222222, SW - 1, SW);
    sc = frame_cyc;
    chk("short_err_count", err_cnt - eb, 1);
    chk("short_no_valid", q_l.size() - vb, 0);
    chk("short_err_latency", err_cyc - sc, 130);
    for (int f = 0; f < 2; f++) send_frame(24'h654321, 24'h0FEDCB, SW, SW);
    chk("short_recover_count", q_l.size() - vb, 2);
    if (q_l.size() - vb >= 2) begin
      chk("short_recover_l", 32'(q_l[vb+1]), 32'h654321);
      chk("short_recover_r", 32'(q_r[vb+1]), 32'h0FEDCB);
    end
    chk("short_err_single", err_cnt - eb, 1);

    // LRCLK stalled low for 100 periods; it merges into the next left slot.
    vb = q_l.size();
    eb = err_cnt;
    for (int i = 0; i < 100; i++) send_bit(1'b0, 1'b0);
    send_frame(24'h777777, 24'h888888, SW, SW);
    chk("stall_err_count", err_cnt - eb, 1);
    chk("stall_no_valid", q_l.size() - vb, 0);
    chk("stall_hold_l", 32'(data_l), 32'h654321);
    chk("stall_hold_r", 32'(data_r), 32'h0FEDCB);
    for (int f = 0; f < 2; f++) send_frame(24'h13579B, 24'h2468AC, SW, SW);
    chk("stall_recover_count", q_l.size() - vb, 2);
    if (q_l.size() - vb >= 2) begin
      chk("stall_recover_l", 32'(q_l[vb]), 32'h13579B);
      chk("stall_recover_r", 32'(q_r[vb]), 32'h2468AC);
    end
    chk("stall_err_single", err_cnt - eb, 1);

    // Master left word changes in the middle of the second frame.
    vb = q_l.size();
    eb = err_cnt;
    master_l = 24'hA5A5A5;
    master_r = 24'h5A5A5A;
    exp_l[0] = 24'hA5A5A5;
    exp_l[1] = 24'hA5A5A5;
    exp_l[2] = 24'h3C3C3C;
    fork
      send_master(3);
      begin
        repeat (380) @(negedge clk_audio);
        master_l = 24'h3C3C3C;
      end
    join
    chk("midchg_count", q_l.size() - vb, 3);
    if (q_l.size() - vb >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("midchg_l%0d", i), 32'(q_l[vb+i]), 32'(exp_l[i]));
        chk($sformatf("midchg_r%0d", i), 32'(q_r[vb+i]), 32'h5A5A5A);
      end
    end
    chk("midchg_no_err", err_cnt - eb, 0);

    chk("valid_err_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
